// File: rtl/muldiv_unit_pkg.sv
// Shared opcode, state and operation-class definitions for the
// iterative multiply/divide unit.
package muldiv_unit_pkg;

    localparam logic [2:0] MD_MUL  = 3'b000;
    localparam logic [2:0] MD_MULS = 3'b001;
    localparam logic [2:0] MD_DIVU = 3'b010;
    localparam logic [2:0] MD_DIVS = 3'b011;
    localparam logic [2:0] MD_MODU = 3'b100;
    localparam logic [2:0] MD_MODS = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } md_state_e;

    typedef enum logic [1:0] {
        K_MUL = 2'd0,
        K_DIV = 2'd1,
        K_MOD = 2'd2
    } md_kind_e;

    // Opcodes 11x fall through to unsigned multiply.
    function automatic md_kind_e md_kind(input logic [2:0] op);
        md_kind_e k;
        k = K_MUL;
        unique case (1'b1)
            (op == MD_DIVU) || (op == MD_DIVS): k = K_DIV;
            (op == MD_MODU) || (op == MD_MODS): k = K_MOD;
            default:                            k = K_MUL;
        endcase
        return k;
    endfunction

    function automatic logic md_signed(input logic [2:0] op);
        return (op == MD_MULS) || (op == MD_DIVS) || (op == MD_MODS);
    endfunction

endpackage

// File: rtl/muldiv_unit_negate.sv
// Conditional two's-complement: used for operand magnitudes and
// for restoring result signs.
module muldiv_negate #(
    parameter int WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    assign dout = neg ? (~din + WIDTH'(1)) : din;

endmodule

// File: rtl/muldiv_unit.sv
// Radix-2 iterative multiply/divide unit: one bit per clock,
// shared adder for shift-add multiply and restoring division.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             start,
    input  logic             abort,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] din_a,
    input  logic [WIDTH-1:0] din_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] dout_hi,
    output logic             cout,
    output logic             vout
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

    md_state_e        state_q;
    md_kind_e         kind_q;
    logic             sgn_q;
    logic             sa_q;
    logic             sb_q;
    logic             dz_q;
    logic             ovf_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] dout_hi_q;
    logic             cout_q;
    logic             vout_q;

    md_kind_e         in_kind;
    logic             in_sgn;
    logic             in_sa;
    logic             in_sb;
    logic             in_dz;
    logic             in_ovf;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    assign in_kind = md_kind(op);
    assign in_sgn  = md_signed(op);
    assign in_sa   = in_sgn & din_a[WIDTH-1];
    assign in_sb   = in_sgn & din_b[WIDTH-1];
    assign in_dz   = (in_kind != K_MUL) && (din_b == '0);
    assign in_ovf  = in_sgn && (in_kind != K_MUL)
                     && (din_a == MIN_V) && (din_b == '1);

    muldiv_negate #(.WIDTH(WIDTH)) u_abs_a (
        .neg  (in_sa),
        .din  (din_a),
        .dout (abs_a)
    );

    muldiv_negate #(.WIDTH(WIDTH)) u_abs_b (
        .neg  (in_sb),
        .din  (din_b),
        .dout (abs_b)
    );

    logic [WIDTH:0]   add_x;
    logic [WIDTH:0]   add_y;
    logic             add_sub;
    logic [WIDTH+1:0] add_r;

    // Subtract path: add_r[WIDTH+1] is the no-borrow flag.
    always_comb begin
        add_x   = {1'b0, hi_q};
        add_y   = lo_q[0] ? {1'b0, m_q} : '0;
        add_sub = 1'b0;
        if (kind_q != K_MUL) begin
            add_x   = {hi_q, lo_q[WIDTH-1]};
            add_y   = {1'b0, m_q};
            add_sub = 1'b1;
        end
    end

    assign add_r = {1'b0, add_x}
                 + {1'b0, (add_sub ? ~add_y : add_y)}
                 + {{(WIDTH+1){1'b0}}, add_sub};

    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    always_comb begin
        step_hi = add_r[WIDTH:1];
        step_lo = {add_r[0], lo_q[WIDTH-1:1]};
        if (kind_q != K_MUL) begin
            if (add_r[WIDTH+1]) begin
                step_hi = add_r[WIDTH-1:0];
                step_lo = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = add_x[WIDTH-1:0];
                step_lo = {lo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    logic             neg_p;
    logic             neg_q;
    logic             neg_r;
    logic [2*WIDTH-1:0] prod_f;
    logic [WIDTH-1:0] quo_f;
    logic [WIDTH-1:0] rem_f;

    assign neg_p = sa_q ^ sb_q;
    assign neg_q = (sa_q ^ sb_q) & ~dz_q;
    assign neg_r = sa_q & ~dz_q;

    muldiv_negate #(.WIDTH(2*WIDTH)) u_fix_prod (
        .neg  (neg_p),
        .din  ({hi_q, lo_q}),
        .dout (prod_f)
    );

    muldiv_negate #(.WIDTH(WIDTH)) u_fix_quo (
        .neg  (neg_q),
        .din  (lo_q),
        .dout (quo_f)
    );

    muldiv_negate #(.WIDTH(WIDTH)) u_fix_rem (
        .neg  (neg_r),
        .din  (hi_q),
        .dout (rem_f)
    );

    logic [WIDTH-1:0] fx_dout;
    logic [WIDTH-1:0] fx_hi;
    logic             fx_cout;
    logic             fx_vout;

    always_comb begin
        fx_dout = prod_f[WIDTH-1:0];
        fx_hi   = prod_f[2*WIDTH-1:WIDTH];
        fx_cout = |hi_q;
        fx_vout = sgn_q
                  && (prod_f[2*WIDTH-1:WIDTH] != {WIDTH{prod_f[WIDTH-1]}});
        unique case (kind_q)
            K_DIV: begin
                fx_dout = quo_f;
                fx_hi   = rem_f;
                fx_cout = 1'b0;
                fx_vout = dz_q | ovf_q;
            end
            K_MOD: begin
                fx_dout = rem_f;
                fx_hi   = quo_f;
                fx_cout = 1'b0;
                fx_vout = dz_q | ovf_q;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q   <= ST_IDLE;
            kind_q    <= K_MUL;
            sgn_q     <= 1'b0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
            m_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dout_q    <= '0;
            dout_hi_q <= '0;
            cout_q    <= 1'b0;
            vout_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        kind_q <= in_kind;
                        sgn_q  <= in_sgn;
                        sa_q   <= in_sa;
                        sb_q   <= in_sb;
                        dz_q   <= in_dz;
                        ovf_q  <= in_ovf;
                        cnt_q  <= CNT_W'(WIDTH);
                        busy_q <= 1'b1;
                        if (in_kind == K_MUL) begin
                            m_q     <= abs_a;
                            hi_q    <= '0;
                            lo_q    <= abs_b;
                            state_q <= ST_RUN;
                        end else if (in_dz) begin
                            m_q     <= abs_b;
                            hi_q    <= din_a;
                            lo_q    <= '1;
                            state_q <= ST_FIX;
                        end else begin
                            m_q     <= abs_b;
                            hi_q    <= '0;
                            lo_q    <= abs_a;
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        hi_q  <= step_hi;
                        lo_q  <= step_lo;
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= ST_FIX;
                        end
                    end
                end
                ST_FIX: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                    if (!abort) begin
                        dout_q    <= fx_dout;
                        dout_hi_q <= fx_hi;
                        cout_q    <= fx_cout;
                        vout_q    <= fx_vout;
                        done_q    <= 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign dout    = dout_q;
    assign dout_hi = dout_hi_q;
    assign cout    = cout_q;
    assign vout    = vout_q;

endmodule
